// File: rtl/soc_run_pkg.sv
// Shared types and constants for the SoC run controller.
package soc_run_pkg;

    localparam int STATE_W   = 3;
    localparam int DEF_CNT_W = 32;

    localparam logic [DEF_CNT_W-1:0] CNT_ONES = '1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

endpackage

// File: rtl/soc_run_if.sv
// Control/status bundle between the run controller (slave) and its driver (master).
interface soc_run_if
    import soc_run_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic               start_i;
    logic               halt_i;
    logic               instret_i;
    logic               core_rst_o;
    logic               core_en_o;
    logic               running_o;
    logic               done_o;
    logic               timeout_o;
    logic [CNT_W-1:0]   cycle_cnt_o;
    logic [CNT_W-1:0]   instret_cnt_o;
    logic [STATE_W-1:0] state_o;

    modport slave (
        input  start_i, halt_i, instret_i,
        output core_rst_o, core_en_o, running_o, done_o, timeout_o,
               cycle_cnt_o, instret_cnt_o, state_o
    );

    modport master (
        output start_i, halt_i, instret_i,
        input  core_rst_o, core_en_o, running_o, done_o, timeout_o,
               cycle_cnt_o, instret_cnt_o, state_o
    );

endinterface

// File: rtl/soc_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter
    import soc_run_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // All-ones at any W, built from the package saturation pattern.
    localparam logic [W-1:0] ONES = {W{CNT_ONES[0]}};

    logic [W-1:0] q_q, q_d;

    // NOTE: default assignment first so no path through the block leaves q_d unassigned (no latch).
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != ONES)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/soc_run_ctrl.sv
// Run controller: sequences core reset release, runs the core, counts cycles and
// retired instructions, and ends the run on halt or cycle-budget expiry.
module soc_run_ctrl
    import soc_run_pkg::*;
#(
    parameter int RST_CYCLES = 5,
    parameter int MAX_CYCLES = 2100,
    parameter int CNT_W      = DEF_CNT_W,
    parameter bit AUTO_START = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    soc_run_if.slave bus
);

    localparam int               RST_LOAD = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int               RC_W     = $clog2(RST_LOAD + 1);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    state_e           state_q;
    logic [RC_W-1:0]  rst_cnt_q;
    logic             core_rst_q, core_en_q, running_q, done_q, timeout_q;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
    logic             in_run, go_reset, timeout_hit;

    assign in_run      = (state_q == ST_RUN);
    assign timeout_hit = (MAX_CYCLES != 0) && (cycle_cnt == LAST_CYC);

    // Only IDLE honours AUTO_START; a finished run needs an explicit start.
    always_comb begin
        go_reset = 1'b0;
        case (state_q)
            ST_IDLE:             go_reset = AUTO_START || bus.start_i;
            ST_DONE, ST_TIMEOUT: go_reset = bus.start_i;
            default:             go_reset = 1'b0;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (go_reset),
        .inc (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk (clk),
        .rst (rst),
        .clr (go_reset),
        .inc (in_run && bus.instret_i),
        .q   (instret_cnt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rst_cnt_q  <= '0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (go_reset) begin
                        state_q    <= ST_RESET;
                        rst_cnt_q  <= RC_W'(RST_LOAD);
                        core_rst_q <= 1'b1;
                        core_en_q  <= 1'b0;
                        running_q  <= 1'b0;
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                ST_RESET: begin
                    rst_cnt_q <= rst_cnt_q - RC_W'(1);
                    if (rst_cnt_q <= RC_W'(1)) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                        core_en_q  <= 1'b1;
                        running_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.halt_i) begin
                        state_q   <= ST_DONE;
                        core_en_q <= 1'b0;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q   <= ST_TIMEOUT;
                        core_en_q <= 1'b0;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    core_rst_q <= 1'b1;
                    core_en_q  <= 1'b0;
                    running_q  <= 1'b0;
                    done_q     <= 1'b0;
                    timeout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rst_o    = core_rst_q;
    assign bus.core_en_o     = core_en_q;
    assign bus.running_o     = running_q;
    assign bus.done_o        = done_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.cycle_cnt_o   = cycle_cnt;
    assign bus.instret_cnt_o = instret_cnt;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Scoreboard bench for soc_run_ctrl: three configurations, expected snapshots are
// queued by the stimulus and compared by a monitor on every state change.
module tb_soc_run_ctrl;
    import soc_run_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    soc_run_if #(.CNT_W(32)) if0 ();
    soc_run_if #(.CNT_W(32)) if1 ();
    soc_run_if #(.CNT_W(32)) if2 ();

    soc_run_ctrl u0 (.clk(clk), .rst(rst0), .bus(if0));
    soc_run_ctrl #(.MAX_CYCLES(10)) u1 (.clk(clk), .rst(rst1), .bus(if1));
    soc_run_ctrl #(.AUTO_START(1'b0), .RST_CYCLES(0)) u2 (.clk(clk), .rst(rst2), .bus(if2));

    typedef struct packed {
        logic [2:0]  st;
        logic        c_rst, c_en, run, dn, tm;
        logic [31:0] cyc, ins;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
        int    dur;   // cycles spent in previous state (transition) or current state (snapshot); -1 = any
        bit    snap;
    } exp_t;

    obs_t obs [3];
    assign obs[0] = {if0.state_o, if0.core_rst_o, if0.core_en_o, if0.running_o, if0.done_o,
                     if0.timeout_o, if0.cycle_cnt_o, if0.instret_cnt_o};
    assign obs[1] = {if1.state_o, if1.core_rst_o, if1.core_en_o, if1.running_o, if1.done_o,
                     if1.timeout_o, if1.cycle_cnt_o, if1.instret_cnt_o};
    assign obs[2] = {if2.state_o, if2.core_rst_o, if2.core_en_o, if2.running_o, if2.done_o,
                     if2.timeout_o, if2.cycle_cnt_o, if2.instret_cnt_o};

    exp_t       exp_q [3][$];
    int         checks = 0;
    int         errors = 0;
    int         len [3] = '{0, 0, 0};
    logic [2:0] last [3] = '{3'd0, 3'd0, 3'd0};
    int         snap_req [3] = '{0, 0, 0};
    int         snap_seen [3] = '{0, 0, 0};
    int         tmo_req = 0;
    int         tmo_seen = 0;
    bit         fin_req = 1'b0;

    function automatic void exp_push(input int k, input string nm, input logic [2:0] st,
                                     input logic c_rst, input logic c_en, input logic run,
                                     input logic dn, input logic tm, input int cyc, input int ins,
                                     input int dur, input bit snap);
        exp_t e;
        e.name = nm;
        e.v    = {st, c_rst, c_en, run, dn, tm, 32'(cyc), 32'(ins)};
        e.dur  = dur;
        e.snap = snap;
        exp_q[k].push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int k, input logic [2:0] st, input int budget);
        int n = 0;
        while (obs[k].st !== st && n < budget) begin
            step();
            n++;
        end
        if (obs[k].st !== st) tmo_req++;
    endtask

    // Monitor: a state change or a requested snapshot consumes one expected record.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin : per_inst
            bit   trans;
            int   pdur;
            int   d;
            exp_t e;
            trans = (obs[k].st !== last[k]);
            pdur  = len[k];
            if (trans) begin
                len[k]  = 1;
                last[k] = obs[k].st;
            end else begin
                len[k]++;
            end
            if (trans || snap_req[k] != snap_seen[k]) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event inst%0d got st=%0d want no event", k, obs[k].st);
                end else begin
                    e = exp_q[k].pop_front();
                    if (e.snap) snap_seen[k]++;
                    d = e.snap ? len[k] : pdur;
                    if (obs[k] !== e.v || (e.dur >= 0 && d != e.dur)) begin
                        errors++;
                        $display("FAIL %s inst%0d got st=%0d rst=%0b en=%0b run=%0b done=%0b to=%0b cyc=%0d ins=%0d dur=%0d want st=%0d rst=%0b en=%0b run=%0b done=%0b to=%0b cyc=%0d ins=%0d dur=%0d",
                                 e.name, k, obs[k].st, obs[k].c_rst, obs[k].c_en, obs[k].run,
                                 obs[k].dn, obs[k].tm, obs[k].cyc, obs[k].ins, d,
                                 e.v.st, e.v.c_rst, e.v.c_en, e.v.run, e.v.dn, e.v.tm,
                                 e.v.cyc, e.v.ins, e.dur);
                    end
                end
            end
        end
        while (tmo_seen != tmo_req) begin
            checks++;
            errors++;
            tmo_seen++;
            $display("FAIL wait_timeout got budget expired want state reached");
        end
        if (fin_req) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (exp_q[k].size() != 0) begin
                    errors++;
                    $display("FAIL leftover_expect inst%0d got %0d pending want 0 (next %s)",
                             k, exp_q[k].size(), exp_q[k][0].name);
                end
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got no completion want summary");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        if0.start_i = 1'b0; if0.halt_i = 1'b0; if0.instret_i = 1'b0;
        if1.start_i = 1'b0; if1.halt_i = 1'b0; if1.instret_i = 1'b0;
        if2.start_i = 1'b0; if2.halt_i = 1'b0; if2.instret_i = 1'b0;
        repeat (3) step();
        rst0 = 1'b0;

        // Defaults: auto start, 5 reset cycles, timeout after 2100 RUN cycles.
        exp_push(0, "boot_reset", ST_RESET,   1, 0, 0, 0, 0, 0,    0,    -1,   0);
        exp_push(0, "boot_run",   ST_RUN,     0, 1, 1, 0, 0, 0,    0,    5,    0);
        exp_push(0, "timeout",    ST_TIMEOUT, 0, 0, 0, 0, 1, 2100, 1050, 2100, 0);
        exp_push(0, "frozen",     ST_TIMEOUT, 0, 0, 0, 0, 1, 2100, 1050, 21,   1);
        if0.instret_i = 1'b1;  // ignored during RESET
        wait_state(0, ST_RUN, 20);
        for (int j = 0; j < 2100; j++) begin
            if0.instret_i = (j % 2 == 0);
            step();
        end
        if0.instret_i = 1'b1;  // instret and halt ignored after timeout
        if0.halt_i    = 1'b1;
        repeat (20) step();
        snap_req[0]++;
        if0.instret_i = 1'b0;
        if0.halt_i    = 1'b0;

        // Restart from TIMEOUT; start held through RUN, halt on RUN cycle 37.
        exp_push(0, "restart_reset", ST_RESET, 1, 0, 0, 0, 0, 0,  0,  21, 0);
        exp_push(0, "restart_run",   ST_RUN,   0, 1, 1, 0, 0, 0,  0,  5,  0);
        exp_push(0, "halt37",        ST_DONE,  0, 0, 0, 1, 0, 37, 10, 37, 0);
        if0.start_i = 1'b1;
        step();
        if0.start_i = 1'b0;
        wait_state(0, ST_RUN, 20);
        if0.start_i   = 1'b1;
        if0.instret_i = 1'b1;
        repeat (10) step();
        if0.instret_i = 1'b0;
        repeat (26) step();
        if0.halt_i = 1'b1;
        step();
        if0.halt_i  = 1'b0;
        if0.start_i = 1'b0;

        // Restart from DONE, then async reset at RUN cycle 100 and auto rerun.
        exp_push(0, "reset_from_done", ST_RESET, 1, 0, 0, 0, 0, 0, 0, 5,   0);
        exp_push(0, "run_third",       ST_RUN,   0, 1, 1, 0, 0, 0, 0, 5,   0);
        exp_push(0, "midrun_rst",      ST_IDLE,  1, 0, 0, 0, 0, 0, 0, 100, 0);
        exp_push(0, "reboot_reset",    ST_RESET, 1, 0, 0, 0, 0, 0, 0, -1,  0);
        exp_push(0, "reboot_run",      ST_RUN,   0, 1, 1, 0, 0, 0, 0, 5,   0);
        repeat (4) step();
        if0.start_i = 1'b1;
        step();
        if0.start_i = 1'b0;
        wait_state(0, ST_RUN, 20);
        repeat (100) step();
        rst0 = 1'b1;
        repeat (2) step();
        rst0 = 1'b0;
        wait_state(0, ST_RUN, 20);

        // MAX_CYCLES=10: halt on the budget edge wins, then a plain timeout run.
        exp_push(1, "m10_reset",   ST_RESET,   1, 0, 0, 0, 0, 0,  0,  -1, 0);
        exp_push(1, "m10_run",     ST_RUN,     0, 1, 1, 0, 0, 0,  0,  5,  0);
        exp_push(1, "m10_halt",    ST_DONE,    0, 0, 0, 1, 0, 10, 0,  10, 0);
        exp_push(1, "m10_reset2",  ST_RESET,   1, 0, 0, 0, 0, 0,  0,  3,  0);
        exp_push(1, "m10_run2",    ST_RUN,     0, 1, 1, 0, 0, 0,  0,  5,  0);
        exp_push(1, "m10_timeout", ST_TIMEOUT, 0, 0, 0, 0, 1, 10, 10, 10, 0);
        rst1 = 1'b0;
        wait_state(1, ST_RUN, 20);
        repeat (9) step();
        if1.halt_i = 1'b1;
        step();
        if1.halt_i = 1'b0;
        repeat (2) step();
        if1.start_i = 1'b1;
        step();
        if1.start_i   = 1'b0;
        if1.instret_i = 1'b1;
        wait_state(1, ST_TIMEOUT, 30);
        if1.instret_i = 1'b0;

        // AUTO_START=0, RST_CYCLES=0: waits in IDLE, single reset cycle.
        rst2 = 1'b0;
        repeat (5) step();
        exp_push(2, "manual_idle", ST_IDLE, 1, 0, 0, 0, 0, 0, 0, -1, 1);
        snap_req[2]++;
        step();
        exp_push(2, "r0_reset", ST_RESET, 1, 0, 0, 0, 0, 0, 0, -1, 0);
        exp_push(2, "r0_run",   ST_RUN,   0, 1, 1, 0, 0, 0, 0, 1,  0);
        exp_push(2, "r0_halt",  ST_DONE,  0, 0, 0, 1, 0, 1, 0, 1,  0);
        if2.start_i = 1'b1;
        step();
        if2.start_i = 1'b0;
        wait_state(2, ST_RUN, 10);
        if2.halt_i = 1'b1;
        step();
        if2.halt_i = 1'b0;

        repeat (3) step();
        fin_req = 1'b1;
    end

endmodule
